// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with memory handshake and optional wait timeout.
// Optional jal support: define CTRL_JAL_EN.
module multicycle_ctrl #(
  parameter int unsigned ALUCTR_W    = 3,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          npc_sel,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic                alu_src,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          ext_op,
  output logic [ALUCTR_W-1:0] alu_ctr,
  output logic [2:0]          state_o,
  output logic                illegal,
  output logic                mem_err
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
`ifdef CTRL_JAL_EN
  localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             tmo;

  logic       legal, is_j, is_jal, is_beq, is_lw, is_sw;
  logic [1:0] d_rdst, d_m2r, d_ext;
  logic       d_asrc;
  logic [2:0] d_alu;

  always_comb begin
    legal  = 1'b1;
    is_j   = 1'b0;
    is_jal = 1'b0;
    is_beq = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    d_rdst = 2'b00;
    d_m2r  = 2'b00;
    d_ext  = 2'b00;
    d_asrc = 1'b0;
    d_alu  = 3'b000;
    case (op)
      OP_R: begin
        d_rdst = 2'b01;
        case (func)
          6'b100000: d_alu = 3'b000;
          6'b100010: d_alu = 3'b100;
          6'b100100: d_alu = 3'b001;
          6'b100101: d_alu = 3'b010;
          6'b101010: d_alu = 3'b111;
          default:   legal = 1'b0;
        endcase
      end
      OP_ORI:  begin d_asrc = 1'b1; d_alu = 3'b010; end
      OP_ADDI: begin d_asrc = 1'b1; d_ext = 2'b01; end
      OP_LW:   begin is_lw = 1'b1; d_asrc = 1'b1; d_ext = 2'b01; d_m2r = 2'b01; end
      OP_SW:   begin is_sw = 1'b1; d_asrc = 1'b1; d_ext = 2'b01; end
      OP_LUI:  begin d_ext = 2'b10; d_m2r = 2'b10; end
      OP_BEQ:  begin is_beq = 1'b1; d_alu = 3'b100; end
      OP_J:    is_j = 1'b1;
`ifdef CTRL_JAL_EN
      OP_JAL:  begin is_jal = 1'b1; d_rdst = 2'b10; d_m2r = 2'b11; end
`endif
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_n    = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    npc_sel    = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    alu_src    = 1'b0;
    mem_to_reg = 2'b00;
    ext_op     = 2'b00;
    alu_ctr    = '0;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    tmo        = (MEM_TIMEOUT != 0) && (cnt == TMO) && !mem_ready;

    // Decoded datapath controls stay stable from EX through WB.
    if (state == S_EX || state == S_MEM || state == S_WB) begin
      reg_dst    = d_rdst;
      alu_src    = d_asrc;
      mem_to_reg = d_m2r;
      ext_op     = d_ext;
      alu_ctr    = ALUCTR_W'(d_alu);
    end

    case (state)
      S_IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_n  = S_ID;
        end else if (tmo) begin
          mem_err = 1'b1;
        end
      end
      S_ID: begin
        state_n = S_EX;
        if (!legal) begin
          illegal = 1'b1;
          state_n = S_IF;
        end else if (is_j || is_jal) begin
          pc_write = 1'b1;
          npc_sel  = 2'b01;
          state_n  = is_jal ? S_WB : S_IF;
        end
      end
      S_EX: begin
        if (is_beq) begin
          pc_write = zero;
          npc_sel  = 2'b10;
          state_n  = S_IF;
        end else if (is_lw || is_sw) begin
          state_n = S_MEM;
        end else begin
          state_n = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          state_n = is_lw ? S_WB : S_IF;
        end else if (tmo) begin
          mem_err = 1'b1;
          state_n = S_IF;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        state_n   = S_IF;
      end
      default: state_n = S_IF;
    endcase

    state_o = state;

    if (!rst_n) begin
      state_o    = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      npc_sel    = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      alu_src    = 1'b0;
      mem_to_reg = 2'b00;
      ext_op     = 2'b00;
      alu_ctr    = '0;
      illegal    = 1'b0;
      mem_err    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IF;
    end else begin
      state <= state_n;
    end
  end

  // An IF abort stays in IF, so the timeout itself must also restart the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_n != state || tmo) begin
      cnt <= '0;
    end else if ((state == S_IF || state == S_MEM) && !mem_ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
